// File: rtl/pre_if_stage_pkg.sv
// Shared types and constants for the pre-fetch stage.
package pre_if_stage_pkg;

    localparam int          PFS_TO_FS_BUS_WD = 104;
    localparam int          BR_BUS_WD        = 34;
    localparam logic [4:0]  EXCODE_ADEL      = 5'h04;
    localparam logic [4:0]  EXCODE_TLBL      = 5'h02;
    localparam logic [31:0] RESET_PC_DEF     = 32'hbfc00000;

    typedef enum logic [1:0] {
        PFS_REQ  = 2'd0,
        PFS_WAIT = 2'd1,
        PFS_DONE = 2'd2
    } pfs_state_e;

    // Field order matches the packed bus, MSB first.
    typedef struct packed {
        logic        tlb_refill;
        logic        inst_ok;
        logic [31:0] inst;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic        ex;
        logic [31:0] pc;
    } pfs_to_fs_bus_t;

endpackage

// File: rtl/pfs_cancel_ctr.sv
// Saturating count of inst_sram responses still owed to cancelled requests.
module pfs_cancel_ctr
    import pre_if_stage_pkg::*;
#(
    parameter int W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] inc_n,
    input  logic       dec,
    output logic       zero
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W+1:0] sum;
    logic         dec_eff;

    // Net the increment against a decrement and clamp at all-ones.
    always_comb begin
        dec_eff = dec && (cnt_q != '0);
        sum     = {2'b00, cnt_q} + {{W{1'b0}}, inc_n} - {{(W+1){1'b0}}, dec_eff};
        cnt_d   = sum[W-1:0];
        if (sum > {2'b00, {W{1'b1}}}) begin
            cnt_d = '1;
        end
    end

    // Count register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pre_if_stage.sv
// Pre-fetch stage: owns the PC, issues inst_sram requests and feeds the IF stage.
//
// state     | meaning
// PFS_REQ   | request for pfs_pc being offered (held back while pfs_pc faults)
// PFS_WAIT  | address accepted, response pending
// PFS_DONE  | response captured in inst_buf, ready for handoff
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CANCEL_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fs_allowin,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    input  logic                        fs_valid_i,
    input  logic                        fs_inst_unable,
    input  logic                        fs_inst_waiting,
    input  logic [BR_BUS_WD-1:0]        br_bus,
    input  logic                        do_flush,
    input  logic [31:0]                 flush_pc,
    input  logic                        itlb_refill,
    input  logic                        itlb_invalid,
    output logic                        inst_sram_req,
    output logic [31:0]                 inst_sram_addr,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata
);

    pfs_state_e     state_q, state_d;
    logic [31:0]    pfs_pc_q, pfs_pc_d;
    logic           tlb_refill_q, tlb_refill_d;
    logic           tlb_invalid_q, tlb_invalid_d;
    logic           br_pend_q, br_pend_d;
    logic [31:0]    br_target_q, br_target_d;
    logic [31:0]    inst_buf_q, inst_buf_d;

    logic           br_stall, br_taken;
    logic [31:0]    br_target;
    logic           adel, tlb_ex, pfs_ex, acc, ready_go;
    logic           br_go, wrong_path, pend_set, cancel, handoff;
    logic           cnt_zero, fs_owns, drop, fs_take, pfs_take;
    logic           inc_pfs, inc_fs;
    logic [1:0]     inc_n;
    logic [31:0]    seq_pc;
    pfs_to_fs_bus_t bus_s;

    assign {br_stall, br_taken, br_target} = br_bus;

    // Request/handoff qualifiers and response ownership for this cycle.
    always_comb begin
        adel       = (pfs_pc_q[1:0] != 2'b00);
        tlb_ex     = tlb_refill_q | tlb_invalid_q;
        pfs_ex     = adel | tlb_ex;
        inst_sram_req  = !reset && (state_q == PFS_REQ) && !pfs_ex;
        inst_sram_addr = pfs_pc_q;
        acc        = inst_sram_req && inst_sram_addr_ok;
        ready_go   = (state_q != PFS_REQ) || acc || pfs_ex;
        pfs_to_fs_valid = !reset && ready_go && !do_flush;

        br_go      = br_taken && !br_stall;
        wrong_path = br_go && fs_valid_i && !do_flush;
        pend_set   = br_go && !fs_valid_i && !do_flush;
        cancel     = do_flush || wrong_path;
        handoff    = pfs_to_fs_valid && fs_allowin && !wrong_path;

        fs_owns    = fs_inst_waiting && !fs_inst_unable;
        drop       = inst_sram_data_ok && !cnt_zero;
        fs_take    = inst_sram_data_ok && cnt_zero && fs_owns;
        pfs_take   = inst_sram_data_ok && cnt_zero && !fs_owns && (state_q == PFS_WAIT);

        // A response consumed this very cycle is no longer owed, so it is not counted.
        inc_pfs    = cancel && (((state_q == PFS_WAIT) && !pfs_take) || acc);
        inc_fs     = do_flush && fs_inst_waiting && !fs_take;
        inc_n      = {1'b0, inc_pfs} + {1'b0, inc_fs};

        // A branch resolving in the handoff cycle redirects that same handoff.
        if (br_pend_q) begin
            seq_pc = br_target_q;
        end else if (pend_set) begin
            seq_pc = br_target;
        end else begin
            seq_pc = pfs_pc_q + 32'd4;
        end
    end

    // Next-state: flush beats wrong-path cancel beats handoff beats local progress.
    // The itlb lookup is for the PC being loaded, so its result is latched with it.
    always_comb begin
        state_d       = state_q;
        pfs_pc_d      = pfs_pc_q;
        tlb_refill_d  = tlb_refill_q;
        tlb_invalid_d = tlb_invalid_q;
        br_pend_d     = br_pend_q;
        br_target_d   = br_target_q;
        inst_buf_d    = inst_buf_q;
        if (cancel || handoff) begin
            pfs_pc_d      = do_flush ? flush_pc : (wrong_path ? br_target : seq_pc);
            state_d       = PFS_REQ;
            tlb_refill_d  = itlb_refill;
            tlb_invalid_d = itlb_invalid;
            br_pend_d     = 1'b0;
            inst_buf_d    = 32'd0;
        end else begin
            if (pend_set) begin
                br_pend_d   = 1'b1;
                br_target_d = br_target;
            end
            if (acc) begin
                state_d = PFS_WAIT;
            end
            if (pfs_take) begin
                state_d    = PFS_DONE;
                inst_buf_d = inst_sram_rdata;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PFS_REQ;
            pfs_pc_q      <= RESET_PC;
            tlb_refill_q  <= 1'b0;
            tlb_invalid_q <= 1'b0;
            br_pend_q     <= 1'b0;
            br_target_q   <= 32'd0;
            inst_buf_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            pfs_pc_q      <= pfs_pc_d;
            tlb_refill_q  <= tlb_refill_d;
            tlb_invalid_q <= tlb_invalid_d;
            br_pend_q     <= br_pend_d;
            br_target_q   <= br_target_d;
            inst_buf_q    <= inst_buf_d;
        end
    end

    pfs_cancel_ctr #(.W(CANCEL_W)) u_cancel_ctr (
        .clk   (clk),
        .reset (reset),
        .inc_n (inc_n),
        .dec   (drop),
        .zero  (cnt_zero)
    );

    // Bus assembly; a response arriving in the handoff cycle rides along directly.
    always_comb begin
        bus_s.tlb_refill = !adel && tlb_refill_q;
        bus_s.inst_ok    = (state_q == PFS_DONE) || pfs_take;
        bus_s.inst       = (state_q == PFS_DONE) ? inst_buf_q :
                           (pfs_take ? inst_sram_rdata : 32'd0);
        bus_s.excode     = adel ? EXCODE_ADEL : (tlb_ex ? EXCODE_TLBL : 5'd0);
        bus_s.badvaddr   = pfs_ex ? pfs_pc_q : 32'd0;
        bus_s.ex         = pfs_ex;
        bus_s.pc         = pfs_pc_q;
    end

    assign pfs_to_fs_bus = bus_s;

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage.
module tb_pre_if_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         fs_allowin;
    logic         pfs_to_fs_valid;
    logic [103:0] pfs_to_fs_bus;
    logic         fs_valid_i;
    logic         fs_inst_unable;
    logic         fs_inst_waiting;
    logic [33:0]  br_bus;
    logic         do_flush;
    logic [31:0]  flush_pc;
    logic         itlb_refill;
    logic         itlb_invalid;
    logic         inst_sram_req;
    logic [31:0]  inst_sram_addr;
    logic         inst_sram_addr_ok;
    logic         inst_sram_data_ok;
    logic [31:0]  inst_sram_rdata;

    pre_if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .fs_valid_i        (fs_valid_i),
        .fs_inst_unable    (fs_inst_unable),
        .fs_inst_waiting   (fs_inst_waiting),
        .br_bus            (br_bus),
        .do_flush          (do_flush),
        .flush_pc          (flush_pc),
        .itlb_refill       (itlb_refill),
        .itlb_invalid      (itlb_invalid),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Bus fields sliced independently of the design's struct.
    wire [31:0] b_pc       = pfs_to_fs_bus[31:0];
    wire        b_ex       = pfs_to_fs_bus[32];
    wire [31:0] b_badvaddr = pfs_to_fs_bus[64:33];
    wire [4:0]  b_excode   = pfs_to_fs_bus[69:65];
    wire [31:0] b_inst     = pfs_to_fs_bus[101:70];
    wire        b_inst_ok  = pfs_to_fs_bus[102];
    wire        b_refill   = pfs_to_fs_bus[103];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        refill;
        logic        invalid;
        logic        ex;
        logic [4:0]  excode;
        logic        tlb_refill;
    } exc_vec_t;

    exc_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Address scoreboard: every accepted request must match the next expected address.
    always @(negedge clk) begin
        if (!reset && inst_sram_req && inst_sram_addr_ok) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL addr_sb: got %h expected none", inst_sram_addr);
            end else begin
                chk("addr_sb", inst_sram_addr, exp_addr_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hbfc00102, 1'b0, 1'b0, 1'b1, 5'h04, 1'b0};
        vecs[1] = '{32'h00400000, 1'b1, 1'b0, 1'b1, 5'h02, 1'b1};
        vecs[2] = '{32'h00400004, 1'b0, 1'b1, 1'b1, 5'h02, 1'b0};
        vecs[3] = '{32'h00400001, 1'b1, 1'b1, 1'b1, 5'h04, 1'b0};
        vecs[4] = '{32'hbfc00003, 1'b0, 1'b0, 1'b1, 5'h04, 1'b0};
        vecs[5] = '{32'hbfc00400, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0};

        reset = 1; fs_allowin = 1; fs_valid_i = 0; fs_inst_unable = 0; fs_inst_waiting = 0;
        br_bus = '0; do_flush = 0; flush_pc = '0; itlb_refill = 0; itlb_invalid = 0;
        inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = '0;
        @(negedge clk);
        chk("rst_valid", 32'(pfs_to_fs_valid), 0);
        chk("rst_req", 32'(inst_sram_req), 0);
        nxt(); reset = 0;
        @(negedge clk);
        chk("t1_req_idle", 32'(inst_sram_req), 1);
        chk("t1_addr0", inst_sram_addr, 32'hbfc00000);
        chk("t1_valid_no_ok", 32'(pfs_to_fs_valid), 0);

        // 1: back-to-back fetches, IF stage owns the responses
        nxt(); fs_inst_waiting = 1;
        for (int i = 0; i < 3; i++) begin
            inst_sram_addr_ok = 1;
            inst_sram_data_ok = (i != 0);
            exp_addr_q.push_back(32'hbfc00000 + 32'(i * 4));
            @(negedge clk);
            chk("t1_valid", 32'(pfs_to_fs_valid), 1);
            chk("t1_pc", b_pc, 32'hbfc00000 + 32'(i * 4));
            nxt();
        end
        inst_sram_addr_ok = 0; inst_sram_data_ok = 1;
        @(negedge clk);
        chk("t1_addr3", inst_sram_addr, 32'hbfc0000c);

        // 2: pfs absorbs a response the IF stage cannot take
        nxt(); inst_sram_data_ok = 0; fs_inst_waiting = 0; fs_inst_unable = 1; fs_allowin = 0;
        inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc0000c);
        @(negedge clk);
        chk("t2_valid_on_ok", 32'(pfs_to_fs_valid), 1);
        nxt(); inst_sram_addr_ok = 0; inst_sram_data_ok = 1; inst_sram_rdata = 32'h24010001;
        @(negedge clk);
        chk("t2_inst_ok_same", 32'(b_inst_ok), 1);
        chk("t2_inst_same", b_inst, 32'h24010001);
        nxt(); inst_sram_data_ok = 0; inst_sram_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_done_inst_ok", 32'(b_inst_ok), 1);
            chk("t2_done_inst", b_inst, 32'h24010001);
            chk("t2_done_req", 32'(inst_sram_req), 0);
            nxt();
        end
        fs_allowin = 1;
        @(negedge clk);
        chk("t2_handoff_pc", b_pc, 32'hbfc0000c);
        nxt(); fs_allowin = 0; fs_inst_unable = 0;
        @(negedge clk);
        chk("t2_next_addr", inst_sram_addr, 32'hbfc00010);
        chk("t2_next_inst_ok", 32'(b_inst_ok), 0);

        // 3: taken branch, delay slot in pfs
        nxt(); inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00010);
        br_bus = {1'b0, 1'b1, 32'hbfc00100};
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; br_bus = '0; inst_sram_data_ok = 1;
        inst_sram_rdata = 32'h8c220000; fs_allowin = 1;
        @(negedge clk);
        chk("t3_slot_pc", b_pc, 32'hbfc00010);
        chk("t3_slot_inst", b_inst, 32'h8c220000);
        nxt(); inst_sram_data_ok = 0; fs_allowin = 0;
        @(negedge clk);
        chk("t3_target_addr", inst_sram_addr, 32'hbfc00100);

        // 4: taken branch, delay slot in IF, pfs in WAIT
        nxt(); inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00100);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; br_bus = {1'b0, 1'b1, 32'hbfc00200}; fs_valid_i = 1;
        @(negedge clk);
        nxt(); br_bus = '0; fs_valid_i = 0;
        @(negedge clk);
        chk("t4_target_addr", inst_sram_addr, 32'hbfc00200);
        nxt(); inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00200);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; inst_sram_data_ok = 1; inst_sram_rdata = 32'hdeadbeef;
        @(negedge clk);
        chk("t4_dropped", 32'(b_inst_ok), 0);
        nxt(); inst_sram_rdata = 32'h11112222;
        @(negedge clk);
        chk("t4_captured_ok", 32'(b_inst_ok), 1);
        chk("t4_captured", b_inst, 32'h11112222);
        nxt(); inst_sram_data_ok = 0; fs_allowin = 1;
        @(negedge clk);
        nxt(); fs_allowin = 0;

        // 5: flush while pfs and IF both wait
        inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00204);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; do_flush = 1; flush_pc = 32'hbfc00380;
        fs_inst_waiting = 1; fs_allowin = 1;
        @(negedge clk);
        chk("t5_flush_valid", 32'(pfs_to_fs_valid), 0);
        nxt(); do_flush = 0; fs_inst_waiting = 0; fs_allowin = 0;
        @(negedge clk);
        chk("t5_flush_addr", inst_sram_addr, 32'hbfc00380);
        nxt(); inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00380);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; inst_sram_data_ok = 1;
        for (int k = 0; k < 2; k++) begin
            inst_sram_rdata = 32'haaaa0001 + 32'(k);
            @(negedge clk);
            chk("t5_dropped", 32'(b_inst_ok), 0);
            nxt();
        end
        inst_sram_rdata = 32'haaaa0003;
        @(negedge clk);
        chk("t5_captured", b_inst, 32'haaaa0003);
        nxt(); inst_sram_data_ok = 0; fs_allowin = 1;
        @(negedge clk);
        nxt(); fs_allowin = 0;

        // Counter saturation: two flushes each owing two responses
        inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00384);
        do_flush = 1; flush_pc = 32'hbfc00500; fs_inst_waiting = 1;
        @(negedge clk);
        nxt(); exp_addr_q.push_back(32'hbfc00500); flush_pc = 32'hbfc00600;
        @(negedge clk);
        nxt(); do_flush = 0; fs_inst_waiting = 0; exp_addr_q.push_back(32'hbfc00600);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; inst_sram_data_ok = 1;
        for (int k = 0; k < 3; k++) begin
            inst_sram_rdata = 32'h5a5a0000 + 32'(k);
            @(negedge clk);
            chk("sat_dropped", 32'(b_inst_ok), 0);
            nxt();
        end
        inst_sram_rdata = 32'h5a5a0003;
        @(negedge clk);
        chk("sat_captured", b_inst, 32'h5a5a0003);
        nxt(); inst_sram_data_ok = 0;

        // Stalled branch is ignored
        br_bus = {1'b1, 1'b1, 32'hbfc00700}; fs_valid_i = 1;
        @(negedge clk);
        nxt(); br_bus = '0; fs_valid_i = 0;
        @(negedge clk);
        chk("stall_pc", b_pc, 32'hbfc00600);
        chk("stall_inst_ok", 32'(b_inst_ok), 1);
        nxt(); fs_allowin = 1;
        @(negedge clk);
        nxt(); fs_allowin = 0;

        // 6: exception table
        for (int v = 0; v < 6; v++) begin
            do_flush = 1; flush_pc = vecs[v].pc;
            itlb_refill = vecs[v].refill; itlb_invalid = vecs[v].invalid;
            @(negedge clk);
            nxt(); do_flush = 0;
            @(negedge clk);
            chk("ex_pc", b_pc, vecs[v].pc);
            chk("ex_flag", 32'(b_ex), 32'(vecs[v].ex));
            chk("ex_code", 32'(b_excode), 32'(vecs[v].excode));
            chk("ex_badv", b_badvaddr, vecs[v].ex ? vecs[v].pc : 32'd0);
            chk("ex_refill", 32'(b_refill), 32'(vecs[v].tlb_refill));
            chk("ex_req", 32'(inst_sram_req), 32'(!vecs[v].ex));
            chk("ex_valid", 32'(pfs_to_fs_valid), 32'(vecs[v].ex));
            nxt();
        end
        itlb_refill = 0; itlb_invalid = 0;

        // PC wraps modulo 2^32
        do_flush = 1; flush_pc = 32'hfffffffc;
        @(negedge clk);
        nxt(); do_flush = 0; inst_sram_addr_ok = 1; fs_allowin = 1;
        exp_addr_q.push_back(32'hfffffffc);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; fs_allowin = 0;
        @(negedge clk);
        chk("wrap_pc", b_pc, 32'h00000000);

        // Reset mid-operation clears an owed response
        nxt(); inst_sram_addr_ok = 1; exp_addr_q.push_back(32'h00000000);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; br_bus = {1'b0, 1'b1, 32'h00001000}; fs_valid_i = 1;
        @(negedge clk);
        nxt(); br_bus = '0; fs_valid_i = 0; reset = 1;
        @(negedge clk);
        chk("midrst_req", 32'(inst_sram_req), 0);
        chk("midrst_valid", 32'(pfs_to_fs_valid), 0);
        nxt(); reset = 0;
        @(negedge clk);
        chk("midrst_pc", b_pc, 32'hbfc00000);
        nxt(); inst_sram_addr_ok = 1; exp_addr_q.push_back(32'hbfc00000);
        @(negedge clk);
        nxt(); inst_sram_addr_ok = 0; inst_sram_data_ok = 1; inst_sram_rdata = 32'h77778888;
        @(negedge clk);
        chk("midrst_captured", b_inst, 32'h77778888);
        nxt(); inst_sram_data_ok = 0;

        chk("sb_empty", 32'(exp_addr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
